// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: HDR0 HDR1 LEN payload CSUM, replaying validated payloads.
// Define FRAME_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle clk cycles.
module uart_frame_parser #(
  parameter logic [7:0]  HDR0        = 8'h55,
  parameter logic [7:0]  HDR1        = 8'hAA,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] data_in,
  input  logic       en_data_in,
  output logic [7:0] pay_out,
  output logic       en_pay_out,
  output logic       pay_last,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("uart_frame_parser: MAX_LEN must be 1..255 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [2:0] {StH0, StH1, StLen, StPay, StCsum, StOut} state_e;

  state_e          r_state, w_state_nxt;
  logic [LW-1:0]   r_len, w_len_nxt;
  logic [LW-1:0]   r_idx, w_idx_nxt;
  logic [7:0]      r_csum, w_csum_nxt;
  logic [7:0]      r_buf [MAX_LEN];
  logic [7:0]      r_pay_out, w_pay_nxt;
  logic            r_en_pay_out, w_en_pay_nxt;
  logic            r_pay_last, w_last_nxt;
  logic            r_frame_err, w_err_nxt;
  logic            w_buf_we;
  logic            w_len_ok;
  logic [LW-1:0]   w_idx_inc;
  logic            w_idx_last;
  logic [IW-1:0]   w_buf_idx;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0]   r_tmo_cnt, w_tmo_nxt;
`endif

  assign w_len_ok   = (data_in != 8'd0) && (32'(data_in) <= MAX_LEN);
  assign w_idx_inc  = r_idx + LW'(1);
  assign w_idx_last = (w_idx_inc == r_len);
  assign w_buf_idx  = r_idx[IW-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_idx_nxt    = r_idx;
    w_csum_nxt   = r_csum;
    w_pay_nxt    = 8'h00;
    w_en_pay_nxt = 1'b0;
    w_last_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_buf_we     = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    w_tmo_nxt    = '0;
`endif

    unique case (r_state)
      StH0: begin
        if (en_data_in && (data_in == HDR0)) w_state_nxt = StH1;
      end
      StH1: begin
        // A repeated HDR0 keeps us aligned on the newest candidate header.
        if (en_data_in) begin
          if (data_in == HDR1)      w_state_nxt = StLen;
          else if (data_in != HDR0) w_state_nxt = StH0;
        end
      end
      StLen: begin
        if (en_data_in) begin
          if (w_len_ok) begin
            w_len_nxt   = LW'(data_in);
            w_csum_nxt  = data_in;
            w_idx_nxt   = '0;
            w_state_nxt = StPay;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = StH0;
          end
        end
      end
      StPay: begin
        if (en_data_in) begin
          w_buf_we   = 1'b1;
          w_csum_nxt = r_csum + data_in;
          w_idx_nxt  = w_idx_inc;
          if (w_idx_last) w_state_nxt = StCsum;
        end
      end
      StCsum: begin
        if (en_data_in) begin
          if (data_in == r_csum) begin
            w_idx_nxt   = '0;
            w_state_nxt = StOut;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = StH0;
          end
        end
      end
      StOut: begin
        // Input strobes are ignored here; the index now walks the buffer for readout.
        w_pay_nxt    = r_buf[w_buf_idx];
        w_en_pay_nxt = 1'b1;
        w_idx_nxt    = w_idx_inc;
        if (w_idx_last) begin
          w_last_nxt  = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = StH0;
        end
      end
      default: w_state_nxt = StH0;
    endcase

`ifdef FRAME_TIMEOUT_EN
    // A strobe in the expiry cycle wins; the counter only runs inside a partial frame.
    if (r_state inside {StH1, StLen, StPay, StCsum}) begin
      if (!en_data_in) begin
        if (r_tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StH0;
        end else begin
          w_tmo_nxt = r_tmo_cnt + TW'(1);
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state      <= StH0;
      r_len        <= '0;
      r_idx        <= '0;
      r_csum       <= 8'h00;
      r_pay_out    <= 8'h00;
      r_en_pay_out <= 1'b0;
      r_pay_last   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_idx        <= w_idx_nxt;
      r_csum       <= w_csum_nxt;
      r_pay_out    <= w_pay_nxt;
      r_en_pay_out <= w_en_pay_nxt;
      r_pay_last   <= w_last_nxt;
      r_frame_err  <= w_err_nxt;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) r_tmo_cnt <= '0;
    else     r_tmo_cnt <= w_tmo_nxt;
  end
`endif

  // Payload storage needs no reset; it is always written before being read.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[w_buf_idx] <= data_in;
  end

  assign pay_out    = r_pay_out;
  assign en_pay_out = r_en_pay_out;
  assign pay_last   = r_pay_last;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == StOut);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; timeout steps depend on FRAME_TIMEOUT_EN.
module tb_uart_frame_parser;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       en_data_in = 1'b0;
  logic [7:0] pay_out;
  logic       en_pay_out;
  logic       pay_last;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic       last;
    time        t;
  } out_t;

  out_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   err_pulses = 0;
  int   err_cycles = 0;
  int   stray_last = 0;
  logic err_prev = 1'b0;
  time  t_set = 0;
  time  t_csum = 0;
  int   e0 = 0;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .HDR0        (8'h55),
    .HDR1        (8'hAA),
    .MAX_LEN     (16),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk        (clk),
    .res        (res),
    .data_in    (data_in),
    .en_data_in (en_data_in),
    .pay_out    (pay_out),
    .en_pay_out (en_pay_out),
    .pay_last   (pay_last),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Output monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #2;
    if (en_pay_out) q.push_back('{d: pay_out, last: pay_last, t: $time});
    if (pay_last && !en_pay_out) stray_last++;
    if (frame_err) begin
      err_cycles++;
      if (!err_prev) err_pulses++;
    end
    err_prev = frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the strobe is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    en_data_in = 1'b1;
    t_set      = $time;
    @(negedge clk);
    en_data_in = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_pay_out", 32'(pay_out), 32'd0);
    check("rst_en_pay_out", 32'(en_pay_out), 32'd0);
    check("rst_pay_last", 32'(pay_last), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    res = 1'b0;
    idle(2);

    // Basic 3-byte frame with latency and busy checks
    q.delete(); e0 = err_pulses;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h09);
    t_csum = t_set;
    check("a_busy_after_csum", 32'(busy), 32'd1);
    check("a_no_early_out", 32'(en_pay_out), 32'd0);
    idle(6);
    check("a_count", 32'(q.size()), 32'd3);
    if (q.size() == 3) begin
      check("a_first_time", 32'(q[0].t - t_csum), 32'd17);
      for (int i = 0; i < 3; i++) begin
        check("a_data", 32'(q[i].d), 32'(i + 1));
        check("a_last", 32'(q[i].last), (i == 2) ? 32'd1 : 32'd0);
        if (i > 0) check("a_consecutive", 32'(q[i].t - q[i-1].t), 32'd10);
      end
    end
    check("a_no_err", 32'(err_pulses - e0), 32'd0);
    check("a_busy_done", 32'(busy), 32'd0);

    // Bad checksum, preceded by noise in H0
    q.delete(); e0 = err_pulses;
    send_byte(8'h12);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    check("b_err_timing", 32'(frame_err), 32'd1);
    idle(4);
    check("b_err_count", 32'(err_pulses - e0), 32'd1);
    check("b_no_output", 32'(q.size()), 32'd0);

    // Header resync, single-byte payload
    send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    send_byte(8'h7F); send_byte(8'h80);
    idle(4);
    check("c_count", 32'(q.size()), 32'd1);
    if (q.size() == 1) begin
      check("c_data", 32'(q[0].d), 32'h7F);
      check("c_last", 32'(q[0].last), 32'd1);
    end
    check("c_err_count", 32'(err_pulses - e0), 32'd1);

    // Length 0 and MAX_LEN+1 rejected, MAX_LEN accepted
    q.delete(); e0 = err_pulses;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
    check("d_len0_err", 32'(frame_err), 32'd1);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11);
    check("d_len17_err", 32'(frame_err), 32'd1);
    idle(3);
    check("d_err_count", 32'(err_pulses - e0), 32'd2);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h98);
    idle(20);
    check("d_count", 32'(q.size()), 32'd16);
    if (q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("d_data", 32'(q[i].d), 32'(i + 1));
        check("d_last", 32'(q[i].last), (i == 15) ? 32'd1 : 32'd0);
        if (i > 0) check("d_consecutive", 32'(q[i].t - q[i-1].t), 32'd10);
      end
    end
    check("d_err_final", 32'(err_pulses - e0), 32'd2);

    // Strobes arriving during OUT are discarded
    q.delete(); e0 = err_pulses;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'h8E);
    check("e_busy", 32'(busy), 32'd1);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7F);
    send_byte(8'h80);
    idle(6);
    check("e_count", 32'(q.size()), 32'd4);
    if (q.size() == 4) begin
      check("e_data3", 32'(q[3].d), 32'hA4);
      check("e_last3", 32'(q[3].last), 32'd1);
    end
    check("e_no_err", 32'(err_pulses - e0), 32'd0);

    // Reset during the second output byte
    q.delete(); e0 = err_pulses;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'h8E);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("f_second_valid", 32'(en_pay_out), 32'd1);
    check("f_second_data", 32'(pay_out), 32'hA2);
    res = 1'b1;
    #1;
    check("f_rst_en", 32'(en_pay_out), 32'd0);
    check("f_rst_data", 32'(pay_out), 32'd0);
    check("f_rst_last", 32'(pay_last), 32'd0);
    check("f_rst_busy", 32'(busy), 32'd0);
    check("f_rst_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    idle(10);
    check("f_no_more_out", 32'(q.size()), 32'd2);
    check("f_en_low", 32'(en_pay_out), 32'd0);

`ifdef FRAME_TIMEOUT_EN
    // Idle timeout aborts a partial frame
    q.delete(); e0 = err_pulses;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h41);
    idle(99);
    check("g_no_early_timeout", 32'(err_pulses - e0), 32'd0);
    idle(1);
    check("g_timeout_err", 32'(frame_err), 32'd1);
    send_byte(8'h42); send_byte(8'h85);
    idle(3);
    check("g_back_in_h0", 32'(q.size()), 32'd0);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7F);
    send_byte(8'h80);
    idle(4);
    check("g_next_frame", 32'(q.size()), 32'd1);
    check("g_err_count", 32'(err_pulses - e0), 32'd1);

    // A strobe in the expiry cycle is processed normally
    q.delete(); e0 = err_pulses;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h41);
    idle(99);
    send_byte(8'h42);
    send_byte(8'h85);
    idle(5);
    check("h_no_err", 32'(err_pulses - e0), 32'd0);
    check("h_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) check("h_data1", 32'(q[1].d), 32'h42);
`else
    // Without the timeout a partial frame waits indefinitely
    q.delete(); e0 = err_pulses;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h41);
    idle(300);
    send_byte(8'h42);
    send_byte(8'h85);
    idle(5);
    check("g_no_err", 32'(err_pulses - e0), 32'd0);
    check("g_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) check("g_data1", 32'(q[1].d), 32'h42);
`endif

    check("z_no_stray_last", 32'(stray_last), 32'd0);
    check("z_err_one_cycle", 32'(err_cycles), 32'(err_pulses));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
